// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the forward and reverse BCD converters.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] BCD_CORR      = 4'd3;
    localparam logic [3:0] DD_THRESH_REV = 4'd8;
    localparam logic [3:0] DD_THRESH_FWD = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble nibble correction: subtract 3 when the nibble is 8 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    // After a right shift a nibble >= 8 carried a half-ten into this digit; undo it.
    assign corrected = (nibble >= DD_THRESH_REV) ? (nibble - BCD_CORR) : nibble;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble: signed packed BCD in, W-bit two's-complement out.
// Latency: done W+1 clocks after the accepted start; 1 clock when a digit is invalid.
// Backpressure: start is only accepted while busy=0; starts during busy are dropped.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  neg,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [W-1:0]          result
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    state_t          state;
    logic [DW-1:0]   digits;
    logic [W-1:0]    acc;
    logic            sign;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            bad_digit;
    logic            last_iter;
    logic [DW-1:0]   sh_digits;
    logic [DW-1:0]   corr_digits;
    logic [W-1:0]    sh_acc;

    // busy is low in IDLE and in the FIN/done cycle, so both can take a new operand.
    assign accept    = start & ~busy;
    assign last_iter = (cnt == CW'(W - 1));

    // One right shift of the combined {digits, acc} register.
    assign sh_digits = digits >> 1;
    assign sh_acc    = {digits[0], acc[W-1:1]};

    // Flag any captured nibble outside 0..9 before committing to a conversion.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_sub3 u_sub3 (
                .nibble    (sh_digits[4*g +: 4]),
                .corrected (corr_digits[4*g +: 4])
            );
        end
    endgenerate

    // Control FSM and datapath; outputs are registered so result lands with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            digits <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    done <= 1'b0;
                    if (accept) begin
                        digits <= bcd_in;
                        acc    <= '0;
                        sign   <= neg;
                        cnt    <= '0;
                        err    <= bad_digit;
                        if (bad_digit) begin
                            // Invalid operand: report immediately, no shifting.
                            state  <= ST_FIN;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    digits <= corr_digits;
                    acc    <= sh_acc;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        // Final shift: acc now holds the magnitude; apply sign here.
                        state  <= ST_FIN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= sign ? (-sh_acc) : sh_acc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin with the default DIGITS=2, W=8.
// Latency: cycle 0 is the cycle start is held high; outputs sampled on falling edges.
// Backpressure: exercises ignored starts, back-to-back starts and mid-run reset.
module tb_bcd_to_bin;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       neg;
    logic [7:0] bcd_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    bcd_to_bin #(.DIGITS(2), .W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .neg    (neg),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at the falling edge of cycle 1.
    task automatic do_start(input logic [7:0] b, input logic n);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        neg    = n;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, result} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b err=%b result=%h expected all zero",
                     busy, done, err, result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [2:0] exp;
        do_start(8'h10, 1'b0);
        bcd_in = 8'h77;
        neg    = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            exp = {(c <= 8), (c == 9), 1'b0};
            checks++;
            if ({busy, done, err} !== exp) begin
                errors++;
                $display("FAIL basic_hs cycle %0d busy/done/err=%b expected %b", c, {busy, done, err}, exp);
            end
            if (c == 9) begin
                checks++;
                if (result !== 8'h0A) begin
                    errors++;
                    $display("FAIL basic_result got %h expected 0a", result);
                end
            end
        end
    endtask

    task automatic test_err;
        do_start(8'h4A, 1'b0);
        checks++;
        if ({busy, done, err, result} !== {3'b011, 8'h00}) begin
            errors++;
            $display("FAIL err_detect busy=%b done=%b err=%b result=%h expected 0 1 1 00",
                     busy, done, err, result);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b001) begin
            errors++;
            $display("FAIL err_hold busy/done/err=%b expected 001", {busy, done, err});
        end
        do_start(8'h37, 1'b0);
        checks++;
        if ({busy, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL err_clear busy/done/err=%b expected 100", {busy, done, err});
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({done, err, result} !== {2'b10, 8'h25}) begin
            errors++;
            $display("FAIL err_next done=%b err=%b result=%h expected 1 0 25", done, err, result);
        end
    endtask

    task automatic test_neg;
        do_start(8'h99, 1'b1);
        repeat (7) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL neg99_cycle8 busy/done=%b expected 10", {busy, done});
        end
        @(negedge clk);
        checks++;
        if ({busy, done, err, result} !== {3'b010, 8'h9D}) begin
            errors++;
            $display("FAIL neg99_result busy=%b done=%b err=%b result=%h expected 0 1 0 9d",
                     busy, done, err, result);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, result} !== {2'b00, 8'h9D}) begin
            errors++;
            $display("FAIL neg99_hold busy=%b done=%b result=%h expected 0 0 9d", busy, done, result);
        end
        do_start(8'h00, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ({done, result} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL neg_zero done=%b result=%h expected 1 00", done, result);
        end
    endtask

    task automatic test_ignore;
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = -1;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h42;
        neg    = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
            end
            if (c <= 8) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_busy cycle %0d busy=%b expected 1", c, busy);
                end
            end
            if (c == 3 || c == 5) begin
                start  = 1'b1;
                bcd_in = 8'h11;
            end else begin
                start  = 1'b0;
            end
        end
        checks++;
        if (ndone != 1 || dcyc != 9) begin
            errors++;
            $display("FAIL ignore_done count=%0d last_cycle=%0d expected 1 at 9", ndone, dcyc);
        end
        checks++;
        if (result !== 8'h2A) begin
            errors++;
            $display("FAIL ignore_result got %h expected 2a", result);
        end
    endtask

    task automatic test_back_to_back;
        int ndone;
        ndone = 0;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h05;
        neg    = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1) bcd_in = 8'h63;
            if (done === 1'b1) ndone++;
            checks++;
            if (done !== ((c == 9) || (c == 18))) begin
                errors++;
                $display("FAIL b2b_done cycle %0d done=%b", c, done);
            end
            if (c == 9 || c == 18) begin
                checks++;
                if (result !== ((c == 9) ? 8'h05 : 8'h3F)) begin
                    errors++;
                    $display("FAIL b2b_result cycle %0d got %h expected %h",
                             c, result, (c == 9) ? 8'h05 : 8'h3F);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 2", ndone);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        do_start(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, result} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b err=%b result=%h expected all zero",
                     busy, done, err, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet activity on %0d cycles expected 0", ndone);
        end
        do_start(8'h21, 1'b0);
        repeat (8) @(negedge clk);
        checks++;
        if ({done, err, result} !== {2'b10, 8'h15}) begin
            errors++;
            $display("FAIL reset_mid_next done=%b err=%b result=%h expected 1 0 15", done, err, result);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        neg    = 1'b0;
        bcd_in = 8'h00;
        test_reset();
        test_basic();
        test_err();
        test_neg();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential reverse double-dabble converter: a packed BCD magnitude plus a sign flag in, a two's-complement binary value out.
- It is the inverse path of the binary-to-BCD display converter. The guessing-game datapath uses it to turn digit-entered guesses (-99..99) into binary for comparison against the LFSR value.
- It runs one shift-right / subtract-3 iteration per clock under a start/busy/done handshake.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in; the most significant digit is at the top.
- W, 8, result width and iteration count. Must satisfy W >= ceil(log2(10^DIGITS)) + 1, so that a sign bit is available.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only when busy=0.
- neg  input  1  sign of the operand (1 = negative); captured with start.
- bcd_in  input  4*DIGITS  packed BCD magnitude; captured with start.
- busy  output  1  conversion in progress.
- done  output  1  single-cycle pulse: result and err are valid.
- err  output  1  last captured operand had a digit > 9; held until the next accepted start.
- result  output  W  signed two's-complement value; held until the next completion.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, err=0, result=0.
  - The shift register and iteration counter are cleared.
  - Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, SHIFT, FIN.
- Accept: start=1 while busy=0 (state IDLE, or FIN during its done cycle) is accepted at cycle 0.
  - Capture: work register {digits, acc} <= {bcd_in, W'b0}, sign <= neg, counter <= 0, err <= 0.
  - Digit check: if any nibble > 9, go to FIN with the err flag set; no shifting is done.
  - Otherwise go to SHIFT.
- SHIFT, once per cycle:
  - Shift the whole {digits, acc} register right by 1 (the digit LSB moves into acc MSB).
  - Then, for each digit, if the post-shift nibble >= 8, subtract 3.
  - counter increments. After W iterations, go to FIN.
  - busy=1 throughout SHIFT, i.e. cycles 1..W.
- FIN, one cycle:
  - done=1 and busy=0.
  - Normal case: result = sign ? -acc : acc, registered so it is visible in the same cycle as done. Latency is W+1 clocks from the start cycle to the done cycle (cycle 9 for defaults).
  - Error case: done is asserted at cycle 1, err=1, result=0.
  - Next state: IDLE, or a new accept if start=1 in this cycle.
- Width and arithmetic:
  - acc is W bits unsigned. Negation is W-bit two's complement.
  - neg=1 with magnitude 0 yields 0 (no negative zero).
  - After W shifts all digit nibbles are 0 for valid input; no check is required.
- Handshake:
  - start while busy=1 is ignored; no latching and no queueing.
  - start held high continuously gives back-to-back conversions, one every W+1 cycles.
  - bcd_in and neg may change freely after the accept cycle.
- done never asserts without a preceding accepted start.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_MAX=9, BCD_CORR=3, DD_THRESH_REV=8, DD_THRESH_FWD=5 (so the forward and reverse converters share the constants).
  - State encoding for IDLE/SHIFT/FIN.
- Sub-module bcd_digit_sub3: a combinational 4-bit nibble that outputs nibble-3 if nibble >= 8, else nibble. Instantiate DIGITS copies in a generate loop.

Test Plan:
- bcd_in=0x10, neg=0, start pulse at cycle 0 -> busy cycles 1..8, done at cycle 9, result=0x0A, err=0.
- bcd_in=0x99, neg=1 -> result=0x9D (-99) at cycle 9; then bcd_in=0x00, neg=1 -> result=0x00.
- bcd_in=0x4A -> done at cycle 1, err=1, result=0x00. The next valid start (0x37) -> err clears at accept, result=0x25.
- Start accepted for 0x42, then start re-pulsed at cycles 3 and 5 with bcd_in=0x11 -> ignored; single done at cycle 9 with result=0x2A.
- start held high continuously, bcd_in changes 0x05 -> 0x63 after the first accept -> done at cycles 9 and 18, results 0x05 then 0x3F.
- rst_n low at cycle 4 of a conversion -> busy/done/err/result=0 immediately; no done pulse afterwards; the next start converts normally.
